// File: rtl/ifu.sv
// Instruction fetch unit: one aligned 8-byte read per instruction,
// 32-bit half selected by pc[2], handed to decode over valid/ready.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   ce_i_ifu, pc_i_ifu      fetch address from the PC stage
//   flush_i_ifu             branch redirect, kills the current fetch
//   stall_o_ifu             PC stage must hold its address
//   req_*_ifu               instruction-memory read request channel
//   rsp_*_ifu               instruction-memory read response channel
//   inst_*_ifu              instruction to decode (valid/ready)
//   misalign_o_ifu          fetch address not 4-byte aligned
module ifu #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64,
   parameter int INST_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ce_i_ifu,
   input  logic [ADDR_W-1:0] pc_i_ifu,
   input  logic              flush_i_ifu,
   output logic              stall_o_ifu,
   output logic              req_valid_o_ifu,
   output logic [ADDR_W-1:0] req_addr_o_ifu,
   input  logic              req_ready_i_ifu,
   input  logic              rsp_valid_i_ifu,
   input  logic [DATA_W-1:0] rsp_data_i_ifu,
   output logic              inst_valid_o_ifu,
   output logic [INST_W-1:0] inst_o_ifu,
   output logic [ADDR_W-1:0] inst_pc_o_ifu,
   output logic              misalign_o_ifu,
   input  logic              inst_ready_i_ifu
);

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      DROP,
      OUT
   } state_e;

   state_e            state_q;
   state_e            state_d;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_d;
   logic [INST_W-1:0] inst_q;
   logic [INST_W-1:0] inst_d;
   logic              mis_q;
   logic              mis_d;

   logic              accept;
   logic              pc_mis;
   logic [INST_W-1:0] rsp_sel;

   assign accept = ce_i_ifu & ~flush_i_ifu;
   assign pc_mis = |pc_i_ifu[1:0];

   // pc_q[2] picks the upper or lower word of the 8-byte beat
   assign rsp_sel = pc_q[2] ? rsp_data_i_ifu[INST_W +: INST_W]
                            : rsp_data_i_ifu[0 +: INST_W];

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      inst_d  = inst_q;
      mis_d   = mis_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               pc_d = pc_i_ifu;
               if (pc_mis) begin
                  inst_d  = '0;
                  mis_d   = 1'b1;
                  state_d = OUT;
               end else begin
                  state_d = REQ;
               end
            end
         end
         REQ: begin
            // an accepted request still owes a response: drain it
            if (flush_i_ifu) begin
               state_d = req_ready_i_ifu ? DROP : IDLE;
            end else if (req_ready_i_ifu) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (rsp_valid_i_ifu) begin
               if (flush_i_ifu) begin
                  state_d = IDLE;
               end else begin
                  inst_d  = rsp_sel;
                  mis_d   = 1'b0;
                  state_d = OUT;
               end
            end else if (flush_i_ifu) begin
               state_d = DROP;
            end
         end
         DROP: begin
            if (rsp_valid_i_ifu) begin
               state_d = IDLE;
            end
         end
         OUT: begin
            if (flush_i_ifu || inst_ready_i_ifu) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pc_q    <= '0;
         inst_q  <= '0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         mis_q   <= mis_d;
      end
   end

   assign stall_o_ifu      = (state_q != IDLE);
   assign req_valid_o_ifu  = (state_q == REQ);
   assign req_addr_o_ifu   = {pc_q[ADDR_W-1:3], 3'b000};
   assign inst_valid_o_ifu = (state_q == OUT);
   assign inst_o_ifu       = inst_q;
   assign inst_pc_o_ifu    = pc_q;
   assign misalign_o_ifu   = mis_q;

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: directed scenarios plus randomized fetches
// checked against a word-select reference model.
module tb_ifu;

   logic        clk;
   logic        rst_n;
   logic        ce;
   logic [63:0] pc_i;
   logic        flush;
   logic        stall;
   logic        req_valid;
   logic [63:0] req_addr;
   logic        req_ready;
   logic        rsp_valid;
   logic [63:0] rsp_data;
   logic        inst_valid;
   logic [31:0] inst;
   logic [63:0] inst_pc;
   logic        mis;
   logic        inst_ready;

   int checks;
   int failures;
   int accepted;
   int exp_accepted;

   ifu #(
      .ADDR_W(64),
      .DATA_W(64),
      .INST_W(32)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .ce_i_ifu         (ce),
      .pc_i_ifu         (pc_i),
      .flush_i_ifu      (flush),
      .stall_o_ifu      (stall),
      .req_valid_o_ifu  (req_valid),
      .req_addr_o_ifu   (req_addr),
      .req_ready_i_ifu  (req_ready),
      .rsp_valid_i_ifu  (rsp_valid),
      .rsp_data_i_ifu   (rsp_data),
      .inst_valid_o_ifu (inst_valid),
      .inst_o_ifu       (inst),
      .inst_pc_o_ifu    (inst_pc),
      .misalign_o_ifu   (mis),
      .inst_ready_i_ifu (inst_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // decode-side model: counts instructions it actually takes
   always @(posedge clk) begin
      if (rst_n && inst_valid && inst_ready && !flush) begin
         accepted++;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   // full fetch from IDLE: ready after rdy_dly, response after
   // rsp_dly more cycles, decode ready after dec_dly cycles of OUT
   task automatic do_fetch(input logic [63:0] pc, input logic [63:0] data,
                           input int rdy_dly, input int rsp_dly,
                           input int dec_dly);
      logic        m;
      logic [31:0] exp_inst;
      m = (pc % 4) != 0;
      if (m) exp_inst = 32'h0;
      else   exp_inst = 32'((data >> (((pc / 4) % 2) * 32)) & 64'hFFFF_FFFF);
      chk("idle_stall", 64'(stall), 64'd0);
      ce   = 1'b1;
      pc_i = pc;
      step();
      ce   = 1'b0;
      pc_i = rnd64();
      if (!m) begin
         for (int i = 0; i <= rdy_dly; i++) begin
            chk("req_valid", 64'(req_valid), 64'd1);
            chk("req_addr", req_addr, pc - (pc % 8));
            chk("req_stall", 64'(stall), 64'd1);
            chk("req_noinst", 64'(inst_valid), 64'd0);
            req_ready = (i == rdy_dly);
            step();
         end
         req_ready = 1'b0;
         for (int i = 0; i <= rsp_dly; i++) begin
            chk("wait_noreq", 64'(req_valid), 64'd0);
            chk("wait_stall", 64'(stall), 64'd1);
            chk("wait_noinst", 64'(inst_valid), 64'd0);
            if (i == rsp_dly) begin
               rsp_valid = 1'b1;
               rsp_data  = data;
            end
            step();
         end
         rsp_valid = 1'b0;
         rsp_data  = rnd64();
      end else begin
         chk("mis_noreq", 64'(req_valid), 64'd0);
      end
      for (int i = 0; i <= dec_dly; i++) begin
         chk("out_valid", 64'(inst_valid), 64'd1);
         chk("out_inst", 64'(inst), 64'(exp_inst));
         chk("out_pc", inst_pc, pc);
         chk("out_mis", 64'(mis), 64'(m));
         chk("out_stall", 64'(stall), 64'd1);
         chk("out_noreq", 64'(req_valid), 64'd0);
         inst_ready = (i == dec_dly);
         step();
      end
      inst_ready = 1'b0;
      exp_accepted++;
      chk("back_idle", 64'(stall), 64'd0);
      chk("back_noinst", 64'(inst_valid), 64'd0);
   endtask

   initial begin
      logic [63:0] p;
      checks       = 0;
      failures     = 0;
      accepted     = 0;
      exp_accepted = 0;
      rst_n      = 1'b0;
      ce         = 1'b0;
      pc_i       = '0;
      flush      = 1'b0;
      req_ready  = 1'b0;
      rsp_valid  = 1'b0;
      rsp_data   = '0;
      inst_ready = 1'b0;
      step();
      step();
      chk("rst_stall", 64'(stall), 64'd0);
      chk("rst_req", 64'(req_valid), 64'd0);
      chk("rst_ival", 64'(inst_valid), 64'd0);
      chk("rst_mis", 64'(mis), 64'd0);
      chk("rst_inst", 64'(inst), 64'd0);
      chk("rst_ipc", inst_pc, 64'd0);
      chk("rst_addr", req_addr, 64'd0);
      rst_n = 1'b1;
      step();

      // best-case aligned, lower word
      do_fetch(64'h8000_0000, 64'h0000_0093_0010_0513, 0, 0, 0);
      // upper word, decode back-pressure
      do_fetch(64'h8000_0004, 64'h0000_0093_0010_0513, 0, 0, 5);
      // misaligned: no memory access
      do_fetch(64'h8000_0002, rnd64(), 0, 0, 0);

      // flush in WAIT, orphan response 3 cycles later
      ce   = 1'b1;
      pc_i = 64'h8000_0010;
      step();
      ce        = 1'b0;
      req_ready = 1'b1;
      step();
      req_ready = 1'b0;
      flush     = 1'b1;
      step();
      flush = 1'b1;
      ce    = 1'b1;
      pc_i  = 64'h8000_0100;
      chk("drop_stall", 64'(stall), 64'd1);
      step();
      flush = 1'b0;
      chk("drop_hold", 64'(stall), 64'd1);
      chk("drop_noreq", 64'(req_valid), 64'd0);
      chk("drop_noinst", 64'(inst_valid), 64'd0);
      step();
      chk("drop_noreq2", 64'(req_valid), 64'd0);
      rsp_valid = 1'b1;
      rsp_data  = rnd64();
      step();
      rsp_valid = 1'b0;
      ce        = 1'b0;
      chk("drop_done", 64'(stall), 64'd0);
      chk("drop_done_ni", 64'(inst_valid), 64'd0);
      do_fetch(64'h8000_0100, 64'h1111_2222_3333_4444, 1, 2, 0);

      // flush in REQ without ready: request withdrawn
      ce   = 1'b1;
      pc_i = 64'h8000_0200;
      step();
      ce = 1'b0;
      chk("freq_valid", 64'(req_valid), 64'd1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("freq_drop", 64'(req_valid), 64'd0);
      chk("freq_idle", 64'(stall), 64'd0);

      // flush in OUT beats a simultaneous ready
      ce   = 1'b1;
      pc_i = 64'h8000_0041;
      step();
      ce = 1'b0;
      chk("fout_valid", 64'(inst_valid), 64'd1);
      flush      = 1'b1;
      inst_ready = 1'b1;
      step();
      flush      = 1'b0;
      inst_ready = 1'b0;
      chk("fout_gone", 64'(inst_valid), 64'd0);
      chk("fout_idle", 64'(stall), 64'd0);

      // reset during WAIT, late response ignored
      ce   = 1'b1;
      pc_i = 64'h8000_0024;
      step();
      ce        = 1'b0;
      req_ready = 1'b1;
      step();
      req_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("mrst_stall", 64'(stall), 64'd0);
      chk("mrst_req", 64'(req_valid), 64'd0);
      chk("mrst_ival", 64'(inst_valid), 64'd0);
      chk("mrst_inst", 64'(inst), 64'd0);
      chk("mrst_ipc", inst_pc, 64'd0);
      chk("mrst_addr", req_addr, 64'd0);
      chk("mrst_mis", 64'(mis), 64'd0);
      #2 rst_n = 1'b1;
      rsp_valid = 1'b1;
      rsp_data  = rnd64();
      step();
      rsp_valid = 1'b0;
      chk("late_idle", 64'(stall), 64'd0);
      chk("late_noinst", 64'(inst_valid), 64'd0);
      do_fetch(64'h8000_0008, 64'hDEAD_BEEF_0BAD_F00D, 0, 0, 0);

      // randomized fetches
      for (int n = 0; n < 60; n++) begin
         p = rnd64();
         if ($urandom_range(0, 4) != 0) p[1:0] = 2'b00;
         do_fetch(p, rnd64(), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3));
      end

      step();
      chk("decode_count", 64'(accepted), 64'(exp_accepted));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit: consumes the fetch address and chip-enable produced by the program-counter register, issues one 8-byte aligned read per instruction on the instruction-memory request/response channel, and hands the selected 32-bit instruction to decode over a valid/ready handshake. It sits between the PC stage and decode in the multi-cycle npc core. It back-pressures the PC stage with `stall_o_ifu` and discards in-flight fetches on branch redirect.

## Interface
- `ADDR_W`, 64, fetch address width
- `DATA_W`, 64, memory response width
- `INST_W`, 32, instruction width

- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `ce_i_ifu`  in  1  PC stage presents a valid fetch address
- `pc_i_ifu`  in  ADDR_W  fetch address
- `flush_i_ifu`  in  1  branch redirect; kill current fetch
- `stall_o_ifu`  out  1  PC stage must hold its address
- `req_valid_o_ifu`  out  1  memory read request valid
- `req_addr_o_ifu`  out  ADDR_W  request address, `{pc_q[ADDR_W-1:3], 3'b000}`
- `req_ready_i_ifu`  in  1  memory accepts request
- `rsp_valid_i_ifu`  in  1  read data valid (one pulse per accepted request)
- `rsp_data_i_ifu`  in  DATA_W  read data
- `inst_valid_o_ifu`  out  1  instruction valid to decode
- `inst_o_ifu`  out  INST_W  instruction
- `inst_pc_o_ifu`  out  ADDR_W  address of `inst_o_ifu`
- `misalign_o_ifu`  out  1  fetch address not 4-byte aligned (qualified by `inst_valid_o_ifu`)
- `inst_ready_i_ifu`  in  1  decode accepts instruction

## Operation
- States: IDLE, REQ, WAIT, DROP, OUT. Reset → IDLE.
- `stall_o_ifu` = (state != IDLE). Address captured only in IDLE.
- IDLE: `ce_i_ifu`=1 and `flush_i_ifu`=0 → latch `pc_q`=`pc_i_ifu`. If `pc_i_ifu[1:0]`!=0: `inst_o_ifu`=0, `misalign_o_ifu`=1, → OUT (no memory access). Otherwise → REQ. `flush_i_ifu`=1 in IDLE: ignore `ce_i_ifu`, stay IDLE. `rsp_valid_i_ifu` in IDLE is ignored.
- REQ: `req_valid_o_ifu`=1, address stable. `req_ready_i_ifu`=1 → WAIT. Flush with ready=1 → DROP; flush with ready=0 → IDLE (request withdrawn; flush is the only case where valid drops without handshake).
- WAIT: `rsp_valid_i_ifu`=1 → `inst_o_ifu` = `pc_q[2]` ? `rsp_data_i_ifu[63:32]` : `rsp_data_i_ifu[31:0]`, `misalign_o_ifu`=0, `inst_pc_o_ifu`=`pc_q`, → OUT. Flush with rsp_valid=1 → IDLE, data discarded; flush with rsp_valid=0 → DROP.
- DROP: wait for the orphan response; `rsp_valid_i_ifu`=1 → IDLE, nothing emitted. Flush ignored.
- OUT: `inst_valid_o_ifu`=1; `inst_o_ifu`, `inst_pc_o_ifu`, `misalign_o_ifu` held stable until accepted. `inst_ready_i_ifu`=1 → IDLE. Flush → IDLE, instruction dropped (flush wins over simultaneous ready).
- At most one memory request outstanding.

## Timing
- Reset (async assert, sync-release assumed upstream): state IDLE; `stall_o_ifu`, `req_valid_o_ifu`, `inst_valid_o_ifu`, `misalign_o_ifu` = 0; `inst_o_ifu`=0; `inst_pc_o_ifu`=0; `req_addr_o_ifu`=0. Reset mid-fetch abandons the request; any late response lands in IDLE and is ignored.
- Best-case latency (ready and response each one cycle): ce sampled edge 0, `req_valid` high cycle 1 with ready, `rsp_valid` cycle 2, `inst_valid` cycle 3. Misaligned: `inst_valid` cycle 1.
- Peak throughput: one instruction per 4 cycles (accept in IDLE the cycle after OUT handshake).
- `req_valid_o_ifu`, `stall_o_ifu` decoded from state register; data outputs registered.

## Test plan
- Aligned fetch, pc=0x80000000, mem returns 0x00000093_00100513, ready/rsp single-cycle → req_addr 0x80000000, inst 0x00100513, inst_pc 0x80000000, valid in cycle 3, stall high cycles 1–3.
- pc=0x80000004, same data, decode ready held low 5 cycles → inst 0x00000093 held stable 5 cycles, stall stays high, returns IDLE after ready.
- pc=0x80000002 → no req_valid ever, misalign=1, inst=0, valid in cycle 1.
- Flush in WAIT before response, response arrives 3 cycles later → state DROP, no inst_valid, next ce with pc=0x80000100 issues req_addr 0x80000100 only after orphan response.
- Flush in REQ with req_ready low → req_valid drops next cycle, no response expected, IDLE; flush in OUT with ready=1 → instruction not counted by decode model.
- rst_n pulsed low during WAIT → all outputs 0 immediately, late rsp_valid ignored, subsequent fetch at 0x80000008 correct.
